// File: rtl/memory_read_collector_3ins.sv
// Read collector for three memory banks: strobes the selected bank, captures its data RD_LAT
// cycles later into a credit-protected FIFO, and returns results in order. Macro: BANK_ERR_EN.
module memory_read_collector_3ins #(
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_sel,
    output logic              bank_rd_en_0,
    output logic              bank_rd_en_1,
    output logic              bank_rd_en_2,
    input  logic [DATA_W-1:0] bank_data_0,
    input  logic [DATA_W-1:0] bank_data_1,
    input  logic [DATA_W-1:0] bank_data_2,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err
);

    localparam int DEPTH = RD_LAT + 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);
`ifdef BANK_ERR_EN
    localparam int EW = DATA_W + 1;
`else
    localparam int EW = DATA_W;
`endif

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CW-1:0]           fill_q, fill_d;
    logic                    req_ready_q, req_ready_d;
    logic [RD_LAT-1:0]       tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0][1:0]  tag_sel_q, tag_sel_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]           mem_q [0:DEPTH-1];

    logic              accept;
    logic              pop;
    logic              wr_en;
    logic [1:0]        wr_sel;
    logic [DATA_W-1:0] wr_data;
    logic [EW-1:0]     wr_entry;
    logic [EW-1:0]     head;

    assign accept    = req_valid && req_ready_q;
    assign req_ready = req_ready_q;
    assign rd_valid  = (fill_q != '0);
    assign pop       = rd_valid && rd_ready;

    assign bank_rd_en_0 = accept && (req_sel == 2'd0);
    assign bank_rd_en_1 = accept && (req_sel == 2'd1);
    assign bank_rd_en_2 = accept && (req_sel == 2'd2);

    // The oldest tag stage lines up with the cycle the bank drives its data.
    assign wr_en  = tag_vld_q[RD_LAT-1];
    assign wr_sel = tag_sel_q[RD_LAT-1];

    always_comb begin
        wr_data = '0;
        case (wr_sel)
            2'd0:    wr_data = bank_data_0;
            2'd1:    wr_data = bank_data_1;
            2'd2:    wr_data = bank_data_2;
            default: wr_data = '0;
        endcase
    end

`ifdef BANK_ERR_EN
    assign wr_entry = {(wr_sel == 2'd3), wr_data};
`else
    assign wr_entry = wr_data;
`endif

    always_comb begin
        tag_vld_d    = '0;
        tag_sel_d    = '0;
        tag_vld_d[0] = accept;
        tag_sel_d[0] = req_sel;
        for (int k = 1; k < RD_LAT; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_sel_d[k] = tag_sel_q[k-1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        fill_d = fill_q;
        case ({wr_en, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + 1'b1;
        end
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + 1'b1;
        end
        // Credits cover every read in flight, so a full count means the FIFO can absorb them all.
        req_ready_d = (cnt_d < DEPTH_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            fill_q      <= '0;
            req_ready_q <= 1'b0;
            tag_vld_q   <= '0;
            tag_sel_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            req_ready_q <= req_ready_d;
            tag_vld_q   <= tag_vld_d;
            tag_sel_q   <= tag_sel_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Storage is not reset, so outputs are forced to zero whenever the FIFO is empty.
    assign head    = mem_q[rd_ptr_q];
    assign rd_data = rd_valid ? head[DATA_W-1:0] : '0;
`ifdef BANK_ERR_EN
    assign rd_err  = rd_valid && head[DATA_W];
`else
    assign rd_err  = 1'b0;
`endif

endmodule

// File: tb/tb_memory_read_collector_3ins.sv
// Scoreboard bench for memory_read_collector_3ins: one instance at RD_LAT=1 and one at RD_LAT=3,
// bank data is a known function of the cycle number so each result is predictable at accept time.
module tb_memory_read_collector_3ins;

`ifdef BANK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          rc;
    } exp_t;

    exp_t sbq [2][$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [1:0]  req_sel   [2];
    logic        en0 [2];
    logic        en1 [2];
    logic        en2 [2];
    logic        rd_valid  [2];
    logic        rd_ready  [2];
    logic [15:0] rd_data   [2];
    logic        rd_err    [2];
    logic [15:0] bd0, bd1, bd2;

    bit          exp_rdy [2];
    bit          acc     [2];
    int          cyc;
    int          n_chk;
    int          n_fail;
    logic [15:0] seed16;

    always #5 clk = ~clk;

    memory_read_collector_3ins #(.DATA_W(16), .RD_LAT(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_sel(req_sel[0]),
        .bank_rd_en_0(en0[0]), .bank_rd_en_1(en1[0]), .bank_rd_en_2(en2[0]),
        .bank_data_0(bd0), .bank_data_1(bd1), .bank_data_2(bd2),
        .rd_valid(rd_valid[0]), .rd_ready(rd_ready[0]), .rd_data(rd_data[0]), .rd_err(rd_err[0])
    );

    memory_read_collector_3ins #(.DATA_W(16), .RD_LAT(3)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_sel(req_sel[1]),
        .bank_rd_en_0(en0[1]), .bank_rd_en_1(en1[1]), .bank_rd_en_2(en2[1]),
        .bank_data_0(bd0), .bank_data_1(bd1), .bank_data_2(bd2),
        .rd_valid(rd_valid[1]), .rd_ready(rd_ready[1]), .rd_data(rd_data[1]), .rd_err(rd_err[1])
    );

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [15:0] bd(input int c, input int n);
        return 16'(c * 40503 + n * 7919 + 1) ^ seed16;
    endfunction

    task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm, input int i);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, i, cyc, act, exp);
        end
    endtask

    // mode: 0 idle/drain, 1 back-to-back 0,1,2, 2 stall consumer, 3 random
    task automatic step(input int mode);
        @(posedge clk);
        #1;
        cyc++;
        bd0 = bd(cyc, 0);
        bd1 = bd(cyc, 1);
        bd2 = bd(cyc, 2);
        for (int i = 0; i < 2; i++) begin
            bit   hold;
            exp_t e;
            hold       = rst_n && req_valid[i] && !exp_rdy[i];
            exp_rdy[i] = rst_n && (sbq[i].size() < lat(i) + 2);
            if (!hold) begin
                case (mode)
                    1: begin req_valid[i] = 1'b1; req_sel[i] = 2'(cyc % 3); end
                    2: begin req_valid[i] = 1'b1; req_sel[i] = 2'($urandom_range(0, 3)); end
                    3: begin req_valid[i] = ($urandom_range(0, 9) < 7); req_sel[i] = 2'($urandom_range(0, 3)); end
                    default: req_valid[i] = 1'b0;
                endcase
            end
            case (mode)
                2:       rd_ready[i] = 1'b0;
                3:       rd_ready[i] = 1'($urandom_range(0, 1));
                default: rd_ready[i] = 1'b1;
            endcase
            acc[i] = rst_n && req_valid[i] && exp_rdy[i];
            if (acc[i]) begin
                e.data = (req_sel[i] == 2'd3) ? 16'h0 : bd(cyc + lat(i), int'(req_sel[i]));
                e.err  = ERR_EN && (req_sel[i] == 2'd3);
                e.rc   = cyc + lat(i) + 1;
                sbq[i].push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                chk(32'(rd_valid[i]), 32'd0, "rst_rd_valid", i);
                chk(32'(req_ready[i]), 32'd0, "rst_req_ready", i);
                chk(32'({en2[i], en1[i], en0[i]}), 32'd0, "rst_strobe", i);
                chk(32'(rd_data[i]), 32'd0, "rst_rd_data", i);
                chk(32'(rd_err[i]), 32'd0, "rst_rd_err", i);
            end else if (cyc > 0) begin
                bit       ev;
                logic [2:0] exp_en;
                exp_en = (acc[i] && req_sel[i] != 2'd3) ? 3'(1 << req_sel[i]) : 3'd0;
                chk(32'(req_ready[i]), 32'(exp_rdy[i]), "req_ready", i);
                chk(32'({en2[i], en1[i], en0[i]}), 32'(exp_en), "bank_rd_en", i);
                ev = (sbq[i].size() > 0) && (sbq[i][0].rc <= cyc);
                chk(32'(rd_valid[i]), 32'(ev), "rd_valid", i);
                if (ev) begin
                    chk(32'(rd_data[i]), 32'(sbq[i][0].data), "rd_data", i);
                    chk(32'(rd_err[i]), 32'(sbq[i][0].err), "rd_err", i);
                    if (rd_ready[i]) void'(sbq[i].pop_front());
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        cyc    = 0;
        n_chk  = 0;
        n_fail = 0;
        seed16 = 16'($urandom);
        bd0 = '0; bd1 = '0; bd2 = '0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_sel[i]   = 2'd0;
            rd_ready[i]  = 1'b0;
            exp_rdy[i]   = 1'b0;
            acc[i]       = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        repeat (3)  step(0);
        repeat (9)  step(1);
        repeat (10) step(0);
        repeat (8)  step(2);
        repeat (12) step(0);
        repeat (8)  step(1);
        repeat (10) step(0);
        repeat (300) step(3);
        repeat (15) step(0);

        // Two reads in flight, then an asynchronous reset in the middle of a cycle.
        repeat (2) step(1);
        step(0);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk(32'(rd_valid[i]), 32'd0, "async_rst_rd_valid", i);
            chk(32'(req_ready[i]), 32'd0, "async_rst_req_ready", i);
            sbq[i].delete();
            exp_rdy[i] = 1'b0;
            acc[i]     = 1'b0;
        end
        repeat (2) step(0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        repeat (10)  step(0);
        repeat (200) step(3);
        repeat (25)  step(0);
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk(32'(sbq[i].size()), 32'd0, "drain_empty", i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
